// File: rtl/pio_led_chaser.sv
// pio_led_chaser: bouncing "Knight Rider" LED sweep driven by a one-bit PIO run flag.
//
// Writing 1 to the PIO starts the sweep. Writing 0 asks it to stop, but the
// current sweep always finishes first: the LEDs go dark only once the lit
// position walks back to 0.
//
// Parameters:
//   NUM_LEDS   number of LEDs driven (2 or more)
//   TICK_DIV   clk cycles per position step (2 or more)
//
// Optional build macro:
//   CHASER_TRAIL_EN  light the previous position as well, so a 2-LED trail
//                    follows the sweep
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   run         run request from the PIO out_port (same clock domain)
//   leds        LED drive, active-high (registered)
//   busy        high while sweeping forward or backward (registered)
//   sweep_done  one-cycle pulse each time a sweep returns to position 0 (registered)
module pio_led_chaser #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  output logic [NUM_LEDS-1:0] leds,
  output logic                busy,
  output logic                sweep_done
);

  localparam int unsigned POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FWD  = 2'd1;
  localparam logic [1:0] BWD  = 2'd2;

  logic [1:0]          state,      state_nxt;
  logic [POS_W-1:0]    pos,        pos_nxt;
  logic [CNT_W-1:0]    cnt,        cnt_nxt;
  logic [NUM_LEDS-1:0] leds_nxt;
  logic                busy_nxt;
  logic                done_nxt;
  logic                tick;

`ifdef CHASER_TRAIL_EN
  logic [POS_W-1:0]    prev_pos,   prev_pos_nxt;
  logic                prev_vld,   prev_vld_nxt;
`endif

  // One-hot decode of a position onto the LED bank.
  function automatic logic [NUM_LEDS-1:0] onehot(input logic [POS_W-1:0] p);
    return NUM_LEDS'(1) << p;
  endfunction

  // The counter is held at 0 in IDLE, so tick can only fire while sweeping.
  assign tick = (cnt == CNT_MAX);

  // Next-state, position, prescaler and output decode.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        pos_nxt = '0;
        cnt_nxt = '0;
        if (run) begin
          state_nxt = FWD;
        end
      end

      FWD: begin
        cnt_nxt = tick ? '0 : cnt + CNT_W'(1);
        if (tick) begin
          // Turn around straight away so the top LED dwells for one tick only.
          if (pos == POS_MAX) begin
            pos_nxt   = pos - POS_ONE;
            state_nxt = BWD;
          end else begin
            pos_nxt = pos + POS_ONE;
          end
        end
      end

      BWD: begin
        cnt_nxt = tick ? '0 : cnt + CNT_W'(1);
        if (tick) begin
          pos_nxt = pos - POS_ONE;
          // run is looked at only here, which is what makes a stop graceful.
          if (pos == POS_ONE) begin
            done_nxt  = 1'b1;
            state_nxt = run ? FWD : IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        pos_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);

`ifdef CHASER_TRAIL_EN
    prev_pos_nxt = prev_pos;
    prev_vld_nxt = prev_vld;
    if (state == IDLE) begin
      // Dropping valid here means the first step after a start is a single LED.
      prev_vld_nxt = 1'b0;
    end else if (tick) begin
      prev_pos_nxt = pos;
      prev_vld_nxt = 1'b1;
    end
    leds_nxt = '0;
    if (state_nxt != IDLE) begin
      leds_nxt = onehot(pos_nxt) | (prev_vld_nxt ? onehot(prev_pos_nxt) : '0);
    end
`else
    leds_nxt = (state_nxt != IDLE) ? onehot(pos_nxt) : '0;
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pos        <= '0;
      cnt        <= '0;
      leds       <= '0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      pos        <= pos_nxt;
      cnt        <= cnt_nxt;
      leds       <= leds_nxt;
      busy       <= busy_nxt;
      sweep_done <= done_nxt;
    end
  end

`ifdef CHASER_TRAIL_EN
  // Trail position register.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pos <= '0;
      prev_vld <= 1'b0;
    end else begin
      prev_pos <= prev_pos_nxt;
      prev_vld <= prev_vld_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_pio_led_chaser.sv
// tb_pio_led_chaser: directed checks of pio_led_chaser with NUM_LEDS=4, TICK_DIV=4.
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_pio_led_chaser;

  logic       clk;
  logic       reset;
  logic       run;
  logic [3:0] leds;
  logic       busy;
  logic       sweep_done;

  int n_tests;
  int n_fail;

  pio_led_chaser #(
    .NUM_LEDS (4),
    .TICK_DIV (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .leds       (leds),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check the current sample, then advance one cycle.
  task automatic sample(input string tag, input logic [3:0] l, input logic b, input logic d);
    check({tag, ".leds"}, 32'(leds), 32'(l));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(sweep_done), 32'(d));
    @(negedge clk);
  endtask

  // n consecutive samples with fixed LEDs/busy and no sweep_done.
  task automatic hold(input string tag, input int n, input logic [3:0] l, input logic b);
    for (int i = 0; i < n; i++) sample(tag, l, b, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    run     = 1'b1;

    // 1. Reset hold with run=1.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst.leds", 32'(leds), 32'h0);
      check("rst.busy", 32'(busy), 32'h0);
      check("rst.done", 32'(sweep_done), 32'h0);
    end
    reset = 1'b0;
    @(negedge clk);

`ifdef CHASER_TRAIL_EN
    // 6. Two-LED trail, then a graceful stop.
    hold("tr0", 4, 4'b0001, 1'b1);
    hold("tr1", 4, 4'b0011, 1'b1);
    hold("tr2", 4, 4'b0110, 1'b1);
    hold("tr3", 4, 4'b1100, 1'b1);
    hold("tr4", 4, 4'b1100, 1'b1);
    hold("tr5", 4, 4'b0110, 1'b1);
    sample("tr_bnd", 4'b0011, 1'b1, 1'b1);
    hold("tr6", 3, 4'b0011, 1'b1);
    run = 1'b0;
    hold("tr7", 4, 4'b0011, 1'b1);
    hold("tr8", 4, 4'b0110, 1'b1);
    hold("tr9", 4, 4'b1100, 1'b1);
    hold("tr10", 4, 4'b1100, 1'b1);
    hold("tr11", 4, 4'b0110, 1'b1);
    sample("tr_stop", 4'b0000, 1'b0, 1'b1);
    hold("tr_idle", 6, 4'b0000, 1'b0);
`else
    // 2. Start and bounce: first 0001 is one cycle after reset release.
    hold("fwd0", 4, 4'b0001, 1'b1);
    hold("fwd1", 4, 4'b0010, 1'b1);
    hold("fwd2", 4, 4'b0100, 1'b1);
    hold("top",  4, 4'b1000, 1'b1);
    hold("bwd2", 4, 4'b0100, 1'b1);
    hold("bwd1", 4, 4'b0010, 1'b1);
    sample("bnd1", 4'b0001, 1'b1, 1'b1);

    // 3. Graceful stop requested while 0100 shows on the way up.
    hold("s_fwd0", 3, 4'b0001, 1'b1);
    hold("s_fwd1", 4, 4'b0010, 1'b1);
    run = 1'b0;
    hold("s_fwd2", 4, 4'b0100, 1'b1);
    hold("s_top",  4, 4'b1000, 1'b1);
    hold("s_bwd2", 4, 4'b0100, 1'b1);
    hold("s_bwd1", 4, 4'b0010, 1'b1);
    sample("s_stop", 4'b0000, 1'b0, 1'b1);
    hold("s_idle", 8, 4'b0000, 1'b0);

    // 4. Stop requested at the top, cancelled at 0010 on the way down.
    run = 1'b1;
    @(negedge clk);
    hold("c_fwd0", 4, 4'b0001, 1'b1);
    hold("c_fwd1", 4, 4'b0010, 1'b1);
    hold("c_fwd2", 4, 4'b0100, 1'b1);
    run = 1'b0;
    hold("c_top",  4, 4'b1000, 1'b1);
    hold("c_bwd2", 4, 4'b0100, 1'b1);
    run = 1'b1;
    hold("c_bwd1", 4, 4'b0010, 1'b1);
    sample("c_bnd", 4'b0001, 1'b1, 1'b1);
    hold("c_fwd0b", 3, 4'b0001, 1'b1);
    hold("c_fwd1b", 4, 4'b0010, 1'b1);
    hold("c_fwd2b", 4, 4'b0100, 1'b1);

    // 5. One-cycle reset at the top of the sweep.
    check("m_top", 32'(leds), 32'b1000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("m_rst.leds", 32'(leds), 32'h0);
    check("m_rst.busy", 32'(busy), 32'h0);
    @(negedge clk);
    hold("m_fwd0", 4, 4'b0001, 1'b1);
    sample("m_fwd1", 4'b0010, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
